// File: rtl/fir_interp_filter.sv
// rtl/fir_interp_filter.sv - interpolating FIR with double-banked coefficients
// Zero-stuffs each accepted sample by UPS and filters every push against the active bank.
module fir_interp_filter #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 71,
  parameter int UPS    = 4,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 0,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_swap,
  output logic              coef_pending,
  output logic              coef_bank
);

  localparam int NT_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int ACC_W = DATA_W + COEF_W + NT_W;
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;
  localparam int PH_W  = (UPS > 1) ? $clog2(UPS) : 1;
  localparam int SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam longint RND_V = (SHIFT > 0) ? (longint'(1) << SH_M1) : 0;
  localparam longint MAX_V = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint MIN_V = -(longint'(1) << (OUT_W - 1));
  localparam logic signed [EXT_W-1:0] RND_C = EXT_W'(RND_V);
  localparam logic signed [EXT_W-1:0] MAX_C = EXT_W'(MAX_V);
  localparam logic signed [EXT_W-1:0] MIN_C = EXT_W'(MIN_V);

  logic signed [DATA_W-1:0] line_q [NTAPS];
  logic signed [DATA_W-1:0] line_d [NTAPS];
  logic signed [COEF_W-1:0] coef_q [2][NTAPS];
  logic signed [COEF_W-1:0] coef_d [2][NTAPS];
  logic [PH_W-1:0]          ph_q, ph_d;
  logic                     bank_q, bank_d;
  logic                     pending_q, pending_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic                     accept, push, swap_now, addr_ok, clip;
  logic signed [ACC_W-1:0]  acc;
  logic signed [EXT_W-1:0]  rnd, shifted;
  logic [OUT_W-1:0]         out_word;

  assign in_ready = !rst && (ph_q == '0);
  assign accept   = in_valid && in_ready;
  assign push     = accept || (ph_q != '0);
  assign addr_ok  = ({1'b0, coef_addr} < (ADDR_W + 1)'(NTAPS));

  always_comb begin
    ph_d = ph_q;
    if (accept) begin
      ph_d = (UPS > 1) ? PH_W'(1) : '0;
    end else if (ph_q != '0) begin
      ph_d = (ph_q == PH_W'(UPS - 1)) ? '0 : ph_q + PH_W'(1);
    end
  end

  // A burst boundary is any edge that leaves ph at zero: last push or an idle edge.
  assign swap_now = pending_q && (ph_d == '0);

  always_comb begin
    bank_d    = swap_now ? ~bank_q : bank_q;
    pending_d = swap_now ? 1'b0 : (pending_q | coef_swap);
  end

  // Writes index the shadow with the pre-swap bank, so a coincident write becomes live.
  always_comb begin
    coef_d = coef_q;
    if (coef_we && addr_ok) begin
      coef_d[~bank_q][coef_addr] = coef_data;
    end
  end

  always_comb begin
    line_d = line_q;
    if (push) begin
      for (int k = NTAPS - 1; k > 0; k--) begin
        line_d[k] = line_q[k-1];
      end
      line_d[0] = accept ? in_data : '0;
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc = acc + ACC_W'(line_d[k]) * ACC_W'(coef_q[bank_q][k]);
    end
  end

  always_comb begin
    rnd      = EXT_W'(acc) + RND_C;
    shifted  = rnd >>> SHIFT;
    clip     = 1'b0;
    out_word = shifted[OUT_W-1:0];
    if (shifted > MAX_C) begin
      clip     = 1'b1;
      out_word = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (shifted < MIN_C) begin
      clip     = 1'b1;
      out_word = {1'b1, {(OUT_W - 1){1'b0}}};
    end
  end

  always_comb begin
    out_valid_d = push;
    out_sat_d   = push && clip;
    out_data_d  = push ? out_word : out_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q      <= '{default: '0};
      coef_q      <= '{default: '0};
      ph_q        <= '0;
      bank_q      <= 1'b0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      line_q      <= line_d;
      coef_q      <= coef_d;
      ph_q        <= ph_d;
      bank_q      <= bank_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sat      = out_sat_q;
  assign coef_pending = pending_q;
  assign coef_bank    = bank_q;

endmodule

// File: doc/fir_interp_filter.md
# fir_interp_filter

Parametrised interpolating FIR for the 64QAM transmit path: accepts symbol-rate samples with a valid/ready handshake, zero-stuffs by UPS, and filters with NTAPS programmable coefficients. Coefficient memory is double-banked, so taps reload while the filter runs and the bank swap lands on a burst boundary. Output is rounded, shifted and saturated to OUT_W, with an overflow flag.

## Interface
- DATA_W, 4: signed input sample width
- COEF_W, 8: signed coefficient width
- NTAPS, 71: tap count, 1..127
- UPS, 4: upsampling factor, 1..16 (1 = plain FIR)
- OUT_W, 12: signed output width
- SHIFT, 0: arithmetic right shift applied before saturation
- ADDR_W, 7: coefficient address width, 2^ADDR_W >= NTAPS
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a sample this cycle
- in_data  in  DATA_W  signed sample
- out_valid  out  1  one-cycle strobe, out_data valid
- out_data  out  OUT_W  signed filtered sample
- out_sat  out  1  strobe with out_valid when saturation clipped the result
- coef_we  in  1  write coef_data into shadow bank
- coef_addr  in  ADDR_W  tap index
- coef_data  in  COEF_W  signed coefficient
- coef_swap  in  1  request shadow/active exchange
- coef_pending  out  1  swap requested, not yet applied
- coef_bank  out  1  index of active bank

## Operation
- Delay line: NTAPS x DATA_W shift register. A push shifts it by one and inserts the new value at tap 0.
- Phase counter `ph`, range 0..UPS-1:
  - in_ready = (ph==0) and not in reset.
  - Accept (in_valid & in_ready) pushes in_data and sets ph to 1 (stays 0 if UPS=1).
  - While ph!=0, each cycle pushes zero and increments ph, wrapping to 0 after UPS-1.
  - A burst is 1 sample plus UPS-1 zeros in consecutive cycles, with no stall.
  - No downstream backpressure.
- MAC per push:
  - acc = sum over k of line_next[k]*coef_active[k].
  - line_next is the delay line after the push.
  - Full precision width DATA_W+COEF_W+ceil(log2(NTAPS)).
- Output arithmetic:
  - If SHIFT>0, add 2^(SHIFT-1), then arithmetic-shift right by SHIFT.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_sat=1 iff a clip occurred.
- Coefficient banks:
  - Two banks of NTAPS x COEF_W. Writes always target the shadow bank (not coef_bank).
  - coef_addr>=NTAPS: write ignored.
  - coef_swap sets pending. A repeat request while pending is absorbed.
  - A pending swap applies at the next burst-boundary edge: the edge where ph returns/stays 0. That is the last push of a burst, or any idle edge with ph==0 and no accept.
  - At the swap, coef_bank toggles and pending clears. The edge's own MAC uses the old bank.
  - coef_we plus swap effective on the same edge: the write lands in the old shadow, which becomes active.
- Reset values: both banks zero, coef_bank 0, coef_pending 0, delay line zero, ph 0, out_valid 0, out_data 0, out_sat 0, in_ready 0 during reset.

## Timing
- Accept at edge k: out_valid high in cycle k+1 with the filtered value. Zeros follow at edges k+1..k+UPS-1.
- Throughput: one input per UPS cycles; one output per cycle during a burst.
- in_ready drops the cycle after an accept when UPS>1 and rises in the cycle ph returns to 0.
  - Back-to-back accepts every UPS cycles give continuous out_valid.
- Swap latency: 1 cycle when idle; up to UPS cycles mid-burst.
- Reset mid-burst clears ph and the line; no further out_valid until a new accept.

## Test plan
- Impulse, UPS=4, NTAPS=71, bank0 loaded with coef[k]=k-35, SHIFT=0:
  - Drive sample +1 then zeros.
  - Expect out_data = coef[0..70] in order, one per push, out_sat 0.
  - out_valid pattern for a single sample = 4 strobes; in_ready low 3 cycles after each accept.
- Saturation, all coef=+127, input -8 held for 71 accepts, OUT_W=12:
  - Expect out_data = -2048 with out_sat=1 once the accumulator passes -2048.
  - SHIFT=4 run: out_data = round(-8*127*n/16) for n loaded nonzero taps.
- Mid-burst swap:
  - Bank0 = 1 at tap0, shadow = 2 at tap0. Accept +3, assert coef_swap at ph=1.
  - Expect outputs 3,0,0,0 from bank0; coef_bank toggles after the 4th push.
  - Next accept of +3 yields 6.
- Idle swap with coincident coef_we to addr 0 = 5: expect coef_bank toggles next edge, coef_pending 0, next impulse +1 gives 5. Write to addr 100 leaves all taps unchanged.
- UPS=1 streaming: in_valid held high for 20 cycles.
  - in_ready stays 1; out_valid continuous with 1-cycle latency; outputs match the reference convolution.
- Async reset asserted at ph=2:
  - All outputs go to reset values immediately; coef_bank 0, banks cleared.
  - After release, in_ready=1 and the first accept produces a fresh impulse response with no residue.
